// File: rtl/snes_poll_scheduler_pkg.sv
// Shared types and constants for the dual-port NES/SNES controller poller.
// Button index constants give the serial bit position of each button.
package snes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } poll_state_t;

    localparam logic MODE_NES  = 1'b0;
    localparam logic MODE_SNES = 1'b1;

    localparam int NES_BITS  = 8;
    localparam int SNES_BITS = 16;

    localparam int SNES_B      = 0;
    localparam int SNES_Y      = 1;
    localparam int SNES_SELECT = 2;
    localparam int SNES_START  = 3;
    localparam int SNES_UP     = 4;
    localparam int SNES_DOWN   = 5;
    localparam int SNES_LEFT   = 6;
    localparam int SNES_RIGHT  = 7;
    localparam int SNES_A      = 8;
    localparam int SNES_X      = 9;
    localparam int SNES_L      = 10;
    localparam int SNES_R      = 11;

    localparam int NES_A      = 0;
    localparam int NES_B      = 1;
    localparam int NES_SELECT = 2;
    localparam int NES_START  = 3;
    localparam int NES_UP     = 4;
    localparam int NES_DOWN   = 5;
    localparam int NES_LEFT   = 6;
    localparam int NES_RIGHT  = 7;

    // A NES pad only owns the low byte; anything shifted in beyond it is noise.
    function automatic logic [15:0] port_word(input logic [15:0] cap, input logic mode);
        return (mode == MODE_SNES) ? cap : {8'h00, cap[7:0]};
    endfunction

endpackage

// File: rtl/snes_poll_scheduler_if.sv
// Pin-side and host-side signals of the controller poller.
// slave = the scheduler, master = whatever drives the pads and consumes buttons.
interface snes_poll_scheduler_if;
    logic [1:0]  Mode;
    logic [1:0]  Data;
    logic        Poll_Req;
    logic        Strobe_Latch;
    logic        Shift_Clock;
    logic [15:0] Buttons0;
    logic [15:0] Buttons1;
    logic        Buttons_Valid;
    logic        Busy;

    modport master (
        output Mode, Data, Poll_Req,
        input  Strobe_Latch, Shift_Clock, Buttons0, Buttons1, Buttons_Valid, Busy
    );

    modport slave (
        input  Mode, Data, Poll_Req,
        output Strobe_Latch, Shift_Clock, Buttons0, Buttons1, Buttons_Valid, Busy
    );
endinterface

// File: rtl/snes_poll_scheduler_phase.sv
// Loadable down-counter timing the LATCH/LOW/HIGH phases.
// Loading value V makes done assert on the V-th cycle after the load edge.
module snes_phase_timer #(
    parameter int W = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val - W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/snes_poll_scheduler.sv
// Shared latch/clock sequencer for two NES/SNES pads with parallel button capture.
// Define SNES_POLL_DEBOUNCE_EN to update a port only on two identical consecutive captures.
module snes_poll_scheduler
    import snes_pkg::*;
#(
    parameter int LATCH_CYCLES       = 600,
    parameter int HALF_BIT_CYCLES    = 300,
    parameter int POLL_PERIOD_CYCLES = 833333
) (
    input  logic                  Clock,
    input  logic                  Reset,
    snes_poll_scheduler_if.slave  bus
);

    localparam int PH_MAX = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
    localparam int PW     = $clog2(PH_MAX + 1);
    localparam int TW     = $clog2(POLL_PERIOD_CYCLES);

    localparam logic [TW-1:0] T_LAST   = TW'(POLL_PERIOD_CYCLES - 1);
    localparam logic [PW-1:0] LATCH_LD = PW'(LATCH_CYCLES);
    localparam logic [PW-1:0] HALF_LD  = PW'(HALF_BIT_CYCLES);
    localparam logic [3:0]    LAST_NES  = 4'(NES_BITS - 1);
    localparam logic [3:0]    LAST_SNES = 4'(SNES_BITS - 1);

    poll_state_t      state;
    logic [TW-1:0]    timer;
    logic             pending;
    logic [1:0]       mode_r;
    logic             n16;
    logic [3:0]       idx;
    logic [1:0][15:0] cap;
    logic [1:0][15:0] btn;
    logic             strobe;
    logic             sclk;
    logic             busy;
    logic             valid;
`ifdef SNES_POLL_DEBOUNCE_EN
    logic [1:0][15:0] prev;
`endif

    logic             start_poll;
    logic             last_bit;
    logic             ph_load;
    logic             ph_done;
    logic [PW-1:0]    ph_val;

    assign start_poll = (state == ST_IDLE) && ((timer == T_LAST) || bus.Poll_Req || pending);
    assign last_bit   = (idx == (n16 ? LAST_SNES : LAST_NES));

    // Reload the phase timer on the edge that enters each timed phase.
    always_comb begin
        ph_load = 1'b0;
        ph_val  = HALF_LD;
        case (state)
            ST_IDLE: begin
                ph_load = start_poll;
                ph_val  = LATCH_LD;
            end
            ST_LATCH, ST_LOW: ph_load = ph_done;
            ST_HIGH:          ph_load = ph_done && !last_bit;
            default:          ph_load = 1'b0;
        endcase
    end

    snes_phase_timer #(.W(PW)) u_phase (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (ph_load),
        .load_val (ph_val),
        .done     (ph_done)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= ST_IDLE;
            timer   <= '0;
            pending <= 1'b0;
            mode_r  <= '0;
            n16     <= 1'b0;
            idx     <= '0;
            cap     <= '0;
            btn     <= '0;
            strobe  <= 1'b0;
            sclk    <= 1'b1;
            busy    <= 1'b0;
            valid   <= 1'b0;
`ifdef SNES_POLL_DEBOUNCE_EN
            prev    <= '0;
`endif
        end else begin
            valid <= 1'b0;

            // Free-running period timer; holds at its last count while a poll overruns.
            if (start_poll)
                timer <= '0;
            else if (timer != T_LAST)
                timer <= timer + TW'(1);

            if (start_poll)
                pending <= 1'b0;
            else if (bus.Poll_Req && state != ST_IDLE)
                pending <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start_poll) begin
                        state  <= ST_LATCH;
                        mode_r <= bus.Mode;
                        n16    <= |bus.Mode;
                        idx    <= '0;
                        cap    <= '0;
                        strobe <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (ph_done) begin
                        state  <= ST_LOW;
                        strobe <= 1'b0;
                        sclk   <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (ph_done) begin
                        for (int p = 0; p < 2; p++)
                            cap[p][idx] <= ~bus.Data[p];
                        state <= ST_HIGH;
                        sclk  <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (ph_done) begin
                        if (last_bit) begin
                            state <= ST_DONE;
                            valid <= 1'b1;
                            for (int p = 0; p < 2; p++) begin
`ifdef SNES_POLL_DEBOUNCE_EN
                                if (port_word(cap[p], mode_r[p]) == prev[p])
                                    btn[p] <= port_word(cap[p], mode_r[p]);
                                prev[p] <= port_word(cap[p], mode_r[p]);
`else
                                btn[p] <= port_word(cap[p], mode_r[p]);
`endif
                            end
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= ST_LOW;
                            sclk  <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.Strobe_Latch  = strobe;
    assign bus.Shift_Clock   = sclk;
    assign bus.Buttons0      = btn[0];
    assign bus.Buttons1      = btn[1];
    assign bus.Buttons_Valid = valid;
    assign bus.Busy          = busy;

endmodule
